// File: rtl/serial_word_framer.sv
// Parallel-in, serial-out word framer: accepts a W-bit word on valid/ready and
// shifts it out LSB first with a frame-start strobe for the downstream complementer.
module serial_word_framer #(
   parameter int W   = 8,
   parameter int GAP = 0
) (
   input  logic         t_clk,
   input  logic         rn,
   input  logic [W-1:0] din,
   input  logic         din_valid,
   output logic         din_ready,
   output logic         sbit,
   output logic         sfirst,
   output logic         slast,
   output logic         sactive,
   output logic [7:0]   frame_cnt
);

   localparam int             IW       = (W > 1) ? $clog2(W) : 1;
   localparam logic [IW-1:0]  LAST_IDX = IW'(W - 1);
   localparam logic [3:0]     GAP_INIT = (GAP > 0) ? 4'(GAP - 1) : 4'd0;
   localparam bit             NO_GAP   = (GAP == 0);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      GAP_ST
   } state_t;

   state_t          state_reg, state_next;
   logic [W-1:0]    sreg_reg, sreg_next;
   logic [IW-1:0]   idx_reg, idx_next;
   logic [3:0]      gcnt_reg, gcnt_next;
   logic            sbit_reg, sfirst_reg, slast_reg, sactive_reg;
   logic [7:0]      frame_cnt_reg;
   logic            word_end;
   logic            xfer;

   assign word_end  = (state_reg == SHIFT) && (idx_reg == LAST_IDX);
   assign din_ready = rn && ((state_reg == IDLE) || (word_end && NO_GAP));
   assign xfer      = din_valid && din_ready;

   always_comb begin
      state_next = state_reg;
      sreg_next  = sreg_reg;
      idx_next   = idx_reg;
      gcnt_next  = gcnt_reg;
      case (state_reg)
         IDLE: begin
            if (xfer) begin
               sreg_next  = din;
               idx_next   = '0;
               state_next = SHIFT;
            end
         end
         SHIFT: begin
            sreg_next = sreg_reg >> 1;
            idx_next  = idx_reg + IW'(1);
            if (word_end) begin
               idx_next = '0;
               if (!NO_GAP) begin
                  gcnt_next  = GAP_INIT;
                  state_next = GAP_ST;
               end else if (xfer) begin
                  sreg_next  = din;
                  state_next = SHIFT;
               end else begin
                  state_next = IDLE;
               end
            end
         end
         GAP_ST: begin
            if (gcnt_reg == 4'd0) begin
               state_next = IDLE;
            end else begin
               gcnt_next = gcnt_reg - 4'd1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Serial outputs are registered from next-state values so they line up
   // with sreg/idx without any combinational path from din.
   always_ff @(posedge t_clk or negedge rn) begin
      if (!rn) begin
         state_reg     <= IDLE;
         sreg_reg      <= '0;
         idx_reg       <= '0;
         gcnt_reg      <= '0;
         sbit_reg      <= 1'b0;
         sfirst_reg    <= 1'b0;
         slast_reg     <= 1'b0;
         sactive_reg   <= 1'b0;
         frame_cnt_reg <= 8'd0;
      end else begin
         state_reg     <= state_next;
         sreg_reg      <= sreg_next;
         idx_reg       <= idx_next;
         gcnt_reg      <= gcnt_next;
         sbit_reg      <= (state_next == SHIFT) && sreg_next[0];
         sfirst_reg    <= (state_next == SHIFT) && (idx_next == '0);
         slast_reg     <= (state_next == SHIFT) && (idx_next == LAST_IDX);
         sactive_reg   <= (state_next == SHIFT);
         if (word_end) begin
            frame_cnt_reg <= frame_cnt_reg + 8'd1;
         end
      end
   end

   assign sbit      = sbit_reg;
   assign sfirst    = sfirst_reg;
   assign slast     = slast_reg;
   assign sactive   = sactive_reg;
   assign frame_cnt = frame_cnt_reg;

endmodule

// File: doc/serial_word_framer.md
# serial_word_framer

Parallel-in, serial-out framer that sits directly upstream of the serial two's-complement stage. It accepts a W-bit word over a valid/ready handshake and shifts it out LSB first, one bit per clock. Alongside each word it drives a one-cycle frame-start strobe, aligned with the LSB, which is wired to the complementer's reset input `r`, so each word is complemented independently. Optional idle gap cycles between words give downstream stages settling time.

## Interface

Parameters:
- `W`, default 8: word width in bits, minimum 1.
- `GAP`, default 0: idle cycles inserted after each word's last bit, range 0..15.

Ports:
- `t_clk` input 1: single clock; all state updates on the rising edge.
- `rn` input 1: asynchronous active-low reset.
- `din` input W: parallel word, sampled on handshake.
- `din_valid` input 1: `din` holds a word.
- `din_ready` output 1: framer can accept a word this cycle (combinational).
- `sbit` output 1: serial data, LSB first; drives the complementer's `i`.
- `sfirst` output 1: high during the bit-0 cycle of each word; drives the complementer's `r`.
- `slast` output 1: high during the bit-(W-1) cycle.
- `sactive` output 1: high while a word bit is being driven.
- `frame_cnt` output 8: count of words fully shifted out; wraps 255 -> 0.

## Operation

- **States:** IDLE, SHIFT, GAP. Bit index register `idx`, width clog2(W) (min 1). Gap counter `gcnt`, 4 bits. Shift register `sreg`, width W.
- **Handshake:** a transfer occurs on a rising edge where `din_valid && din_ready`.
- **`din_ready` is asserted when:**
  - the state is IDLE, or
  - the state is SHIFT, `idx == W-1` and `GAP == 0` (back-to-back).
- **`din_ready` is forced to 0 while `rn` is low.**
- **IDLE:** on transfer, load `sreg <= din`, set `idx <= 0`, go to SHIFT. With no transfer, stay in IDLE.
- **SHIFT:** outputs `sbit = sreg[0]`, `sactive = 1`, `sfirst = (idx == 0)`, `slast = (idx == W-1)`. On each edge, `sreg` shifts right and `idx` increments.
- **Word end (edge where `idx == W-1`):**
  - `frame_cnt` increments.
  - With `GAP > 0`: `gcnt <= GAP-1`, go to GAP.
  - With `GAP == 0`: a concurrent transfer reloads `sreg` and `idx <= 0` and stays in SHIFT; with no transfer, go to IDLE.
- **GAP:** `sactive = 0`. `gcnt` decrements each edge; on the edge where `gcnt == 0`, go to IDLE.
- **Outputs outside SHIFT:** `sbit`, `sfirst`, `slast` and `sactive` are all 0 in IDLE and GAP.
- **Registered outputs:** `sbit`, `sfirst`, `slast`, `sactive` and `frame_cnt` are driven from flops. There is no combinational path from `din` or `din_valid` to them.
- **W == 1:** `sfirst` and `slast` are high in the same cycle.
- **Input stability:** `din` changing while `din_valid` is high without a handshake is legal; only the value at the handshake edge matters.

## Timing

- **Reset (`rn` low):** state IDLE, `sreg`/`idx`/`gcnt` 0, `sbit`/`sfirst`/`slast`/`sactive` 0, `frame_cnt` 0, `din_ready` 0.
- **Reset mid-word:** outputs clear immediately and asynchronously. The partial word is dropped and `frame_cnt` is not incremented. After `rn` rises, `din_ready` is 1 in the same cycle.
- **Latency:** bit 0 appears on `sbit` in the first cycle after the handshake edge. Bit k appears k cycles later.
- **Word duration:** W cycles of `sactive`, followed by GAP cycles of idle.
- **Throughput:**
  - `GAP == 0` with continuous `din_valid`: one word per W cycles, with no bubble between words.
  - Otherwise: one word per W+GAP+1 cycles (one IDLE cycle per word).
- **`frame_cnt` update:** visible in the cycle after the `slast` cycle.
- **Downstream alignment:** the complementer samples `sfirst`/`sbit` on the same `t_clk` edge. Its output bit therefore appears with the complementer's internal delay, and the framer adds no extra alignment stage.

## Test plan

- **Single word:** `W=8`, `GAP=0`, `din=8'h06` with a single handshake.
  - `sbit` = 0,1,1,0,0,0,0,0 over cycles 1-8.
  - `sfirst` high in cycle 1 only; `slast` high in cycle 8 only.
  - Complementer output reassembled = `8'hFA`.
  - `frame_cnt` = 1 from cycle 9.
- **Back-to-back:** `GAP=0`, `din_valid` held high with words `8'h01` then `8'h80`.
  - `din_ready` high in cycle 8.
  - 16 contiguous `sactive` cycles; `sfirst` high in cycles 1 and 9.
  - Reassembled complements `8'hFF` and `8'h80`.
- **Gap insertion:** `GAP=2`, `din_valid` held high with two words.
  - `sactive` low for 2 GAP cycles plus 1 IDLE cycle between words.
  - `din_ready` low throughout SHIFT and GAP.
- **Reset mid-word:** pull `rn` low during bit 3 of `8'hA5`.
  - All outputs drop to 0 immediately; `frame_cnt` stays 0.
  - After release, `8'h3C` shifts out cleanly with `sfirst` on its bit 0.
- **W=1:** `W=1`, stream 1,0,1 with `din_valid` held high.
  - `sfirst` = `slast` = 1 every cycle.
  - `sbit` = 1,0,1.
  - `frame_cnt` reaches 3.
- **Counter wrap and backpressure:**
  - Send 256 words with random `din_valid` gaps: `frame_cnt` wraps to 0.
  - No handshake while `din_valid` is low, and no word is lost or duplicated.
